// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator: default geometry,
// sequencing states and the window pixel type.
package sobel_pkg;

  localparam int DEF_PIX_W      = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef logic [DEF_PIX_W-1:0] win_pix_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: write on the clock edge, combinational read of
// the same address, so a read in the write cycle returns the previous line.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int WIDTH = DEF_PIX_W,
  localparam int AW = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to registered 3x3 neighbourhood for the Sobel stage;
// two line buffers supply the older rows, border positions emit no window.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic             CK,
  input  logic             RES,
  input  logic [PIX_W-1:0] PIX_IN,
  input  logic             PIX_VALID,
  input  logic             PIX_SOF,
  output logic [PIX_W-1:0] S00,
  output logic [PIX_W-1:0] S01,
  output logic [PIX_W-1:0] S02,
  output logic [PIX_W-1:0] S10,
  output logic [PIX_W-1:0] S11,
  output logic [PIX_W-1:0] S12,
  output logic [PIX_W-1:0] S20,
  output logic [PIX_W-1:0] S21,
  output logic [PIX_W-1:0] S22,
  output logic             WIN_VALID,
  output logic             WIN_EOF
);

  // state   | meaning
  // IDLE    | waiting for a start-of-frame pixel, others dropped
  // FILL    | rows 0..1, line buffers priming, no windows
  // RUN     | rows 2..last, windows emitted from column 2 onward

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [RW-1:0]    row_q, row_d, row_eff;
  logic [PIX_W-1:0] win_q [3][3];
  logic             win_valid_q, win_eof_q;
  logic             sof, accept, at_line_end, at_frame_end, lb_we;
  logic [PIX_W-1:0] top_pix, mid_pix;

  // SOF forces the current pixel to (0,0), abandoning any partial frame.
  assign sof          = PIX_VALID & PIX_SOF;
  assign accept       = sof | (PIX_VALID & (state_q != ST_IDLE));
  assign col_eff      = sof ? '0 : col_q;
  assign row_eff      = sof ? '0 : row_q;
  assign at_line_end  = (col_eff == COL_LAST);
  assign at_frame_end = at_line_end & (row_eff == ROW_LAST);
  assign lb_we        = accept & ~RES;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (at_line_end) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
      if (sof) begin
        state_d = ST_FILL;
      end else begin
        case (state_q)
          ST_FILL: if (at_line_end && row_eff == ROW_ONE) state_d = ST_RUN;
          ST_RUN:  if (at_frame_end) state_d = ST_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RES) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_eof_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= accept && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
      win_eof_q   <= accept && at_frame_end;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= top_pix;
        win_q[1][2] <= mid_pix;
        win_q[2][2] <= PIX_IN;
      end
    end
  end

  // LB0 holds the oldest line, LB1 the previous one; each accepted pixel
  // ages LB1's entry into LB0 and stores the new pixel in LB1.
  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk_i   (CK),
    .addr_i  (col_eff),
    .we_i    (lb_we),
    .wdata_i (mid_pix),
    .rdata_o (top_pix)
  );

  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk_i   (CK),
    .addr_i  (col_eff),
    .we_i    (lb_we),
    .wdata_i (PIX_IN),
    .rdata_o (mid_pix)
  );

  assign S00       = win_q[0][0];
  assign S01       = win_q[0][1];
  assign S02       = win_q[0][2];
  assign S10       = win_q[1][0];
  assign S11       = win_q[1][1];
  assign S12       = win_q[1][2];
  assign S20       = win_q[2][0];
  assign S21       = win_q[2][1];
  assign S22       = win_q[2][2];
  assign WIN_VALID = win_valid_q;
  assign WIN_EOF   = win_eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 5x4 image; expected windows
// come from the stored frame image, indexed directly by window position.
module tb_sobel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       CK = 1'b0;
  logic       RES = 1'b1;
  logic [7:0] PIX_IN = '0;
  logic       PIX_VALID = 1'b0;
  logic       PIX_SOF = 1'b0;
  logic [7:0] S00, S01, S02, S10, S11, S12, S20, S21, S22;
  logic       WIN_VALID, WIN_EOF;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img_m [H][W];
  logic [71:0] first_win, last_win;
  int          npulse;
  logic        last_eof;

  sobel_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (8)
  ) dut (
    .CK        (CK),
    .RES       (RES),
    .PIX_IN    (PIX_IN),
    .PIX_VALID (PIX_VALID),
    .PIX_SOF   (PIX_SOF),
    .S00       (S00),
    .S01       (S01),
    .S02       (S02),
    .S10       (S10),
    .S11       (S11),
    .S12       (S12),
    .S20       (S20),
    .S21       (S21),
    .S22       (S22),
    .WIN_VALID (WIN_VALID),
    .WIN_EOF   (WIN_EOF)
  );

  always #5 CK = ~CK;

  function automatic logic [71:0] s_vec();
    return {S00, S01, S02, S10, S11, S12, S20, S21, S22};
  endfunction

  // Window completed by pixel (r,c): rows r-2..r, columns c-2..c of the image.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[63:0], img_m[r-2+i][c-2+j]};
    return v;
  endfunction

  task automatic fill_img(input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img_m[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'(r * 16 + c);
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] p, input logic r);
    RES = r; PIX_VALID = v; PIX_SOF = s; PIX_IN = p;
    @(posedge CK);
    #1;
  endtask

  // Streams img_m as one frame; gap_mode >= 0 inserts that many idle cycles
  // after each pixel, gap_mode < 0 inserts a random 0..2.
  task automatic send_frame(input int gap_mode);
    logic [71:0] exp_q[$];
    logic [71:0] snap;
    int gaps;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        exp_q.push_back(exp_win(r, c));
    npulse = 0;
    last_eof = 1'b0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), img_m[r][c], 1'b0);
        checks++;
        if (WIN_VALID !== (r >= 2 && c >= 2)) begin
          errors++;
          $display("FAIL frame_valid r%0d c%0d: got %b want %b", r, c, WIN_VALID, (r >= 2 && c >= 2));
        end
        checks++;
        if (WIN_EOF !== (r == H - 1 && c == W - 1)) begin
          errors++;
          $display("FAIL frame_eof r%0d c%0d: got %b want %b", r, c, WIN_EOF, (r == H - 1 && c == W - 1));
        end
        if (WIN_VALID === 1'b1) begin
          if (npulse == 0) first_win = s_vec();
          last_win = s_vec();
          last_eof = WIN_EOF;
          npulse++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_extra_window r%0d c%0d: got %h want none", r, c, s_vec());
          end else begin
            snap = exp_q.pop_front();
            if (s_vec() !== snap) begin
              errors++;
              $display("FAIL frame_window r%0d c%0d: got %h want %h", r, c, s_vec(), snap);
            end
          end
        end
        snap = s_vec();
        gaps = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
        for (int g = 0; g < gaps; g++) begin
          step(1'b0, 1'b0, 8'($urandom), 1'b0);
          checks++;
          if (WIN_VALID !== 1'b0 || WIN_EOF !== 1'b0 || s_vec() !== snap) begin
            errors++;
            $display("FAIL gap_hold r%0d c%0d: got v%b e%b %h want v0 e0 %h",
                     r, c, WIN_VALID, WIN_EOF, s_vec(), snap);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_missing: got %0d windows short, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'(i), 1'b0, 8'($urandom), 1'b1);
      checks++;
      if (s_vec() !== 72'h0 || WIN_VALID !== 1'b0 || WIN_EOF !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got v%b e%b %h want v0 e0 0", WIN_VALID, WIN_EOF, s_vec());
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (s_vec() !== 72'h0 || WIN_VALID !== 1'b0) begin
        errors++;
        $display("FAIL reset_drop_no_sof: got v%b %h want v0 0", WIN_VALID, s_vec());
      end
    end
  endtask

  task automatic test_continuous();
    fill_img(1'b0);
    send_frame(0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (npulse != 6) begin
      errors++;
      $display("FAIL cont_pulses: got %0d want 6", npulse);
    end
    checks++;
    if (first_win !== 72'h000102101112202122) begin
      errors++;
      $display("FAIL cont_first: got %h want 000102101112202122", first_win);
    end
    checks++;
    if (last_win[7:0] !== 8'h34 || last_win[71:64] !== 8'h12 || last_eof !== 1'b1) begin
      errors++;
      $display("FAIL cont_last: got S22 %h S00 %h eof %b want 34 12 1",
               last_win[7:0], last_win[71:64], last_eof);
    end
  endtask

  task automatic test_gaps();
    fill_img(1'b0);
    send_frame(2);
    checks++;
    if (npulse != 6 || first_win !== 72'h000102101112202122) begin
      errors++;
      $display("FAIL gaps_frame: got %0d pulses first %h want 6 000102101112202122", npulse, first_win);
    end
  endtask

  task automatic test_sof_restart();
    for (int i = 0; i < W + 3; i++) begin
      step(1'b1, (i == 0), 8'($urandom), 1'b0);
      checks++;
      if (WIN_VALID !== 1'b0) begin
        errors++;
        $display("FAIL restart_partial i%0d: got %b want 0", i, WIN_VALID);
      end
    end
    fill_img(1'b0);
    send_frame(0);
    checks++;
    if (first_win[71:64] !== 8'h00 || npulse != 6) begin
      errors++;
      $display("FAIL restart_first: got S00 %h pulses %0d want 00 6", first_win[71:64], npulse);
    end
  endtask

  task automatic test_trailing();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (WIN_VALID !== 1'b0 || WIN_EOF !== 1'b0) begin
        errors++;
        $display("FAIL trailing_pixels i%0d: got v%b e%b want v0 e0", i, WIN_VALID, WIN_EOF);
      end
    end
    fill_img(1'b0);
    send_frame(0);
    checks++;
    if (npulse != 6 || first_win !== 72'h000102101112202122 || last_eof !== 1'b1) begin
      errors++;
      $display("FAIL trailing_next_frame: got %0d %h %b want 6 000102101112202122 1",
               npulse, first_win, last_eof);
    end
  endtask

  task automatic test_mid_reset();
    fill_img(1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 4) break;
        step(1'b1, (r == 0 && c == 0), img_m[r][c], 1'b0);
        if (r == 2 && c >= 2) begin
          checks++;
          if (WIN_VALID !== 1'b1 || s_vec() !== exp_win(r, c)) begin
            errors++;
            $display("FAIL midrst_window c%0d: got v%b %h want v1 %h", c, WIN_VALID, s_vec(), exp_win(r, c));
          end
        end
      end
    end
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    checks++;
    if (s_vec() !== 72'h0 || WIN_VALID !== 1'b0 || WIN_EOF !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cleared: got v%b e%b %h want v0 e0 0", WIN_VALID, WIN_EOF, s_vec());
    end
    for (int i = 0; i < W + 1; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (WIN_VALID !== 1'b0 || s_vec() !== 72'h0) begin
        errors++;
        $display("FAIL midrst_resume i%0d: got v%b %h want v0 0", i, WIN_VALID, s_vec());
      end
    end
    fill_img(1'b1);
    send_frame(0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fill_img(1'b1);
      send_frame(-1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      fill_img(1'b1);
      send_frame(0);
      checks++;
      if (npulse != 6) begin
        errors++;
        $display("FAIL b2b_pulses k%0d: got %0d want 6", k, npulse);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_sof_restart();
    test_trailing();
    test_mid_reset();
    test_random();
    test_back_to_back();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Upstream neighbour of the Sobel edge stage. Accepts a raster-order 8-bit grayscale pixel stream and keeps two line buffers. It presents a registered 3x3 neighbourhood (S00..S22) to the Sobel filter, with a qualifying valid strobe. Border pixels (first two rows and columns of each frame) produce no window; no padding is applied.

Parameters:
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
PIX_W, 8, pixel width in bits

Ports:
CK  input  1  clock; all logic on rising edge
RES  input  1  synchronous active-high reset
PIX_IN  input  PIX_W  incoming pixel, raster order
PIX_VALID  input  1  PIX_IN valid this cycle; always accepted, no backpressure
PIX_SOF  input  1  marks first pixel (0,0) of a frame; only meaningful with PIX_VALID
S00,S01,S02,S10,S11,S12,S20,S21,S22  output  PIX_W each  window; row 0 = oldest line, column 2 = newest pixel
WIN_VALID  output  1  window valid, one-cycle pulse per emitted window
WIN_EOF  output  1  asserted together with WIN_VALID on the last window of a frame

Behaviour:
- Reset (RES high on a rising edge, synchronous, overrides all inputs): S00..S22=0, WIN_VALID=0, WIN_EOF=0, col=0, row=0, state=IDLE. Line buffer RAM is not cleared; stale contents are never exposed (gated by counters).
- "Accept" = PIX_VALID=1 and state allows it (see FSM). Cycles without accept: all window registers hold, WIN_VALID=0, WIN_EOF=0.
- FSM states: IDLE (wait for SOF), FILL (row 0..1), RUN (row>=2).
  IDLE -> FILL on PIX_VALID&PIX_SOF; pixels without SOF in IDLE are dropped.
  FILL -> RUN on accepting pixel (1, IMG_WIDTH-1).
  RUN -> IDLE on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  PIX_VALID&PIX_SOF in any state: pixel treated as (0,0), counters restart, partial frame abandoned, state -> FILL.
- Counters: col 0..IMG_WIDTH-1 wraps to 0 and increments row; row 0..IMG_HEIGHT-1. Widths $clog2 of the respective parameter.
- Per accepted pixel at column c (single read-before-write access per buffer):
  top = LB0[c], mid = LB1[c]; LB0[c] <= mid; LB1[c] <= PIX_IN.
  Window shift: Sx0<=Sx1, Sx1<=Sx2 for x=0,1,2; S02<=top, S12<=mid, S22<=PIX_IN.
- WIN_VALID <= accept && row>=2 && col>=2 (pre-increment coordinates). Latency: window and strobe visible one cycle after the completing pixel's accept edge.
- WIN_EOF <= accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2). The window centre is pixel (row-1, col-1).
- Window columns 0/1 at line start hold the previous line's data. This is legal because WIN_VALID is gated by col>=2.
- No arithmetic on pixel values; pass-through only.

Decomposition:
- Shared package sobel_pkg: PIX_W default, IMG_WIDTH/IMG_HEIGHT defaults, FSM state enum (IDLE, FILL, RUN), window pixel typedef.
- Sub-module sobel_line_buffer: single-port RAM, depth IMG_WIDTH, width PIX_W, synchronous read-before-write, no reset. Instantiated twice (LB0, LB1). Read data must be available in time for the same-cycle window update: asynchronous read, or a registered read with a matching one-stage pipeline on the pixel path. Implementer chooses; total latency above is fixed.

Test Plan:
All tests use IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col.
1. Reset: RES high 2 cycles with PIX_VALID toggling -> all S=0x00, WIN_VALID=0, WIN_EOF=0 throughout; pixels before SOF are dropped.
2. Continuous frame (SOF on first pixel, PIX_VALID=1 for 20 cycles) -> exactly 6 WIN_VALID pulses.
   First pulse: cycle after pixel (2,2); S00..S22 = 00,01,02,10,11,12,20,21,22.
   Last pulse: S22=0x34, S00=0x12, with WIN_EOF=1.
3. Same frame with PIX_VALID pattern 1,0,0,1,... -> identical 6 windows in order; outputs stable and WIN_VALID=0 during gaps.
4. SOF re-asserted at pixel (1,3), then a full frame -> no window from the abandoned frame; first pulse follows new pixel (2,2) with S00=0x00.
5. 10 extra PIX_VALID pixels after frame end, no SOF -> no WIN_VALID. Next SOF frame behaves as test 2.
6. RES asserted for 1 cycle after pixel (2,3) -> next cycle all S=0, WIN_VALID=0. Stream resumed without SOF yields nothing until the next SOF.
